// File: rtl/disp_scan_engine.sv
// Eight-digit display scan engine: owns the digit scan, snapshots the time/date/alarm
// fields once per frame, converts the year to BCD sequentially and blinks the edited pair.
module disp_scan_engine #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 250,
  parameter int YEAR_W    = 14,
  parameter int ROC_BASE  = 1911
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        mode,
  input  logic [2:0]        alarm_mode,
  input  logic [5:0]        hour,
  input  logic [5:0]        minute,
  input  logic [5:0]        second,
  input  logic [5:0]        temp_hour,
  input  logic [5:0]        temp_minute,
  input  logic [5:0]        temp_second,
  input  logic [3:0]        month,
  input  logic [4:0]        day,
  input  logic [2:0]        week,
  input  logic [YEAR_W-1:0] year,
  input  logic [1:0]        edit_field,
  output logic [2:0]        light,
  output logic [7:0]        digit_en,
  output logic [3:0]        num,
  output logic              frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int CW = $clog2(YEAR_W + 1);
  localparam int SW = 6 * 6 + 4 + 5 + 3 + YEAR_W;

  typedef enum logic [1:0] {IDLE, CONV_AD, CONV_ROC, LOAD} conv_state_e;

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [2:0]    light_q, light_d;
  logic [7:0]    digit_en_q, digit_en_d;
  logic          frame_tick_q, frame_tick_d;
  logic [3:0]    num_q, num_d;
  logic [SW-1:0] snap_q, snap_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [1:0]    edit_prev_q, edit_prev_d;
  logic          wrap, frame_ev;

  conv_state_e   state_q;
  logic [CW-1:0] bit_cnt_q;
  logic [YEAR_W-1:0] bin_q;
  logic [15:0]   bcd_q, ad_bcd_q, roc_bcd_q, disp_ad_q, disp_roc_q;
  logic          disp_ovf_q;

  logic [5:0] hour_s, minute_s, second_s, thour_s, tmin_s, tsec_s;
  logic [3:0] month_s;
  logic [4:0] day_s;
  logic [2:0] week_s;
  logic [YEAR_W-1:0] year_s;

  assign {hour_s, minute_s, second_s, thour_s, tmin_s, tsec_s,
          month_s, day_s, week_s, year_s} = snap_q;

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    logic [5:0] t;
    t = v / 6'd10;
    return t[3:0];
  endfunction

  function automatic logic [3:0] units_of(input logic [5:0] v);
    logic [5:0] u;
    u = v - 6'd10 * (v / 6'd10);
    return u[3:0];
  endfunction

  // One double-dabble iteration: add-3 on every nibble >= 5, then shift the next bit in.
  function automatic logic [15:0] dd_step(input logic [15:0] bcd, input logic din);
    logic [15:0] adj;
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return {adj[14:0], din};
  endfunction

  function automatic logic in_pair(input logic [2:0] idx, input logic [1:0] ef);
    case (ef)
      2'd1:    return (idx == 3'd0) || (idx == 3'd1);
      2'd2:    return (idx == 3'd3) || (idx == 3'd4);
      2'd3:    return (idx == 3'd6) || (idx == 3'd7);
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    wrap         = (prescaler_q == PW'(SCAN_DIV - 1));
    prescaler_d  = wrap ? '0 : prescaler_q + PW'(1);
    light_d      = wrap ? light_q + 3'd1 : light_q;
    digit_en_d   = 8'b1 << light_d;
    frame_ev     = wrap && (light_q == 3'd7);
    frame_tick_d = frame_ev;
    snap_d       = frame_ev ? {hour, minute, second, temp_hour, temp_minute, temp_second,
                               month, day, week, year} : snap_q;
  end

  // An edit_field change restarts the blink in its visible half.
  always_comb begin
    edit_prev_d   = edit_field;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (edit_field != edit_prev_q) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (frame_tick_q) begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_comb begin
    logic [5:0]  a, b, c;
    logic [15:0] src;
    logic        is_date;
    num_d   = 4'd15;
    is_date = (mode == 3'd2);
    a = hour_s;
    b = minute_s;
    c = second_s;
    if (mode == 3'd5 && alarm_mode != 3'd0) begin
      a = thour_s;
      b = tmin_s;
      c = tsec_s;
    end
    if (is_date) begin
      a = {2'b00, month_s};
      b = {1'b0, day_s};
    end
    src = light_q[2] ? disp_roc_q : disp_ad_q;
    case (mode)
      3'd1, 3'd2, 3'd5: begin
        case (light_q)
          3'd0:    num_d = tens_of(a);
          3'd1:    num_d = units_of(a);
          3'd3:    num_d = tens_of(b);
          3'd4:    num_d = units_of(b);
          3'd6:    num_d = is_date ? 4'd11 : tens_of(c);
          3'd7:    num_d = is_date ? {1'b0, week_s} : units_of(c);
          default: num_d = 4'd11;
        endcase
      end
      3'd3: begin
        if (disp_ovf_q) begin
          num_d = 4'd12;
        end else begin
          case (light_q[1:0])
            2'd0:    num_d = src[15:12];
            2'd1:    num_d = src[11:8];
            2'd2:    num_d = src[7:4];
            default: num_d = src[3:0];
          endcase
        end
      end
      default: num_d = 4'd15;
    endcase
    if (!blink_phase_q && in_pair(light_q, edit_field)) num_d = 4'd15;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler_q   <= '0;
      light_q       <= 3'd0;
      digit_en_q    <= 8'h01;
      frame_tick_q  <= 1'b0;
      num_q         <= 4'd15;
      snap_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      edit_prev_q   <= 2'd0;
    end else begin
      prescaler_q   <= prescaler_d;
      light_q       <= light_d;
      digit_en_q    <= digit_en_d;
      frame_tick_q  <= frame_tick_d;
      num_q         <= num_d;
      snap_q        <= snap_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      edit_prev_q   <= edit_prev_d;
    end
  end

  // Year converter: AD pass, optional ROC pass, then a single-cycle load into the display set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      ad_bcd_q   <= '0;
      roc_bcd_q  <= '0;
      disp_ad_q  <= '0;
      disp_roc_q <= '0;
      disp_ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_tick_q) begin
            bin_q     <= year_s;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= CONV_AD;
          end
        end
        CONV_AD: begin
          bcd_q     <= dd_step(bcd_q, bin_q[YEAR_W-1]);
          bin_q     <= bin_q << 1;
          bit_cnt_q <= bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(YEAR_W - 1)) begin
            ad_bcd_q  <= dd_step(bcd_q, bin_q[YEAR_W-1]);
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            if (year_s >= YEAR_W'(ROC_BASE) && year_s <= YEAR_W'(9999)) begin
              bin_q   <= year_s - YEAR_W'(ROC_BASE);
              state_q <= CONV_ROC;
            end else begin
              roc_bcd_q <= 16'hCCCC;
              state_q   <= LOAD;
            end
          end
        end
        CONV_ROC: begin
          bcd_q     <= dd_step(bcd_q, bin_q[YEAR_W-1]);
          bin_q     <= bin_q << 1;
          bit_cnt_q <= bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(YEAR_W - 1)) begin
            roc_bcd_q <= dd_step(bcd_q, bin_q[YEAR_W-1]);
            bit_cnt_q <= '0;
            state_q   <= LOAD;
          end
        end
        default: begin
          disp_ad_q  <= ad_bcd_q;
          disp_roc_q <= roc_bcd_q;
          disp_ovf_q <= (year_s > YEAR_W'(9999));
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign light      = light_q;
  assign digit_en   = digit_en_q;
  assign num        = num_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_engine.sv
// Randomised bench for disp_scan_engine, checked against an arithmetic per-frame digit model.
module tb_disp_scan_engine;
  localparam int SD = 32;
  localparam int BD = 2;
  localparam int YW = 14;
  localparam int RB = 1911;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] mode = 3'd0, alarm_mode = 3'd0;
  logic [5:0] hour = 6'd0, minute = 6'd0, second = 6'd0;
  logic [5:0] temp_hour = 6'd0, temp_minute = 6'd0, temp_second = 6'd0;
  logic [3:0] month = 4'd0;
  logic [4:0] day = 5'd0;
  logic [2:0] week = 3'd0;
  logic [YW-1:0] year = '0;
  logic [1:0] edit_field = 2'd0;
  logic [2:0] light;
  logic [7:0] digit_en;
  logic [3:0] num;
  logic frame_tick;

  int errors = 0;
  int checks = 0;
  logic [3:0] got_num[8];
  logic [2:0] got_light[8];
  logic [7:0] got_en[8];

  disp_scan_engine #(.SCAN_DIV(SD), .BLINK_DIV(BD), .YEAR_W(YW), .ROC_BASE(RB)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .alarm_mode(alarm_mode),
    .hour(hour), .minute(minute), .second(second),
    .temp_hour(temp_hour), .temp_minute(temp_minute), .temp_second(temp_second),
    .month(month), .day(day), .week(week), .year(year), .edit_field(edit_field),
    .light(light), .digit_en(digit_en), .num(num), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected symbol for digit d from the current bench inputs.
  function automatic int model_digit(input int d);
    int v[8];
    int a, b, c, yr, r;
    for (int i = 0; i < 8; i++) v[i] = 15;
    yr = int'(year);
    a = int'(hour); b = int'(minute); c = int'(second);
    if (mode == 3'd5 && alarm_mode != 3'd0) begin
      a = int'(temp_hour); b = int'(temp_minute); c = int'(temp_second);
    end
    if (mode == 3'd2) begin
      a = int'(month); b = int'(day);
    end
    if (mode == 3'd1 || mode == 3'd2 || mode == 3'd5) begin
      v[0] = a / 10; v[1] = a % 10; v[2] = 11;
      v[3] = b / 10; v[4] = b % 10; v[5] = 11;
      if (mode == 3'd2) begin
        v[6] = 11; v[7] = int'(week);
      end else begin
        v[6] = c / 10; v[7] = c % 10;
      end
    end else if (mode == 3'd3) begin
      if (yr > 9999) begin
        for (int i = 0; i < 8; i++) v[i] = 12;
      end else begin
        v[0] = yr / 1000; v[1] = (yr / 100) % 10; v[2] = (yr / 10) % 10; v[3] = yr % 10;
        if (yr < RB) begin
          for (int i = 4; i < 8; i++) v[i] = 12;
        end else begin
          r = yr - RB;
          v[4] = r / 1000; v[5] = (r / 100) % 10; v[6] = (r / 10) % 10; v[7] = r % 10;
        end
      end
    end
    return v[d];
  endfunction

  function automatic bit pair_of(input int d, input int ef);
    return (ef == 1 && (d == 0 || d == 1)) || (ef == 2 && (d == 3 || d == 4)) ||
           (ef == 3 && (d == 6 || d == 7));
  endfunction

  task automatic wait_tick();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL tick_timeout: got no frame_tick, required one within 600 cycles");
  endtask

  // Waits for the next frame and samples each digit in the middle of its slot.
  task automatic grab_frame();
    int pos;
    wait_tick();
    pos = 0;
    for (int d = 0; d < 8; d++) begin
      repeat (d * SD + 16 - pos) @(negedge clk);
      pos = d * SD + 16;
      got_num[d] = num;
      got_light[d] = light;
      got_en[d] = digit_en;
    end
  endtask

  task automatic test_reset();
    int cnt;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (num !== 4'd15) begin errors++; $display("FAIL reset_num: got %0d required 15", num); end
    checks++;
    if (light !== 3'd0) begin errors++; $display("FAIL reset_light: got %0d required 0", light); end
    checks++;
    if (digit_en !== 8'h01) begin errors++; $display("FAIL reset_en: got %h required 01", digit_en); end
    checks++;
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b required 0", frame_tick); end
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (light === 3'd1) break;
    end
    checks++;
    if (cnt != SD) begin errors++; $display("FAIL reset_first_step: got %0d clks required %0d", cnt, SD); end
  endtask

  task automatic test_scan();
    int n;
    wait_tick();
    n = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        checks++;
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL tick_width: got %b required 0", frame_tick); end
      end
      if (frame_tick === 1'b1) break;
    end
    checks++;
    if (n != 8 * SD) begin errors++; $display("FAIL tick_period: got %0d required %0d", n, 8 * SD); end
    grab_frame();
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (got_light[d] !== 3'(d)) begin errors++; $display("FAIL scan_light%0d: got %0d required %0d", d, got_light[d], d); end
      checks++;
      if (got_en[d] !== (8'b1 << d)) begin errors++; $display("FAIL scan_en%0d: got %h required %h", d, got_en[d], 8'b1 << d); end
    end
  endtask

  task automatic test_time();
    int exp_t[8] = '{2, 3, 11, 0, 5, 11, 5, 9};
    mode = 3'd1; alarm_mode = 3'd0; hour = 6'd23; minute = 6'd5; second = 6'd59;
    wait_tick();
    grab_frame();
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (got_num[d] !== 4'(exp_t[d])) begin errors++; $display("FAIL time_digit%0d: got %0d required %0d", d, got_num[d], exp_t[d]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      mode = 3'($urandom_range(0, 7));
      alarm_mode = 3'($urandom_range(0, 7));
      if (it < 4) mode = 3'(it == 0 ? 1 : it == 1 ? 2 : it == 2 ? 3 : 5);
      hour = 6'($urandom); minute = 6'($urandom); second = 6'($urandom);
      temp_hour = 6'($urandom); temp_minute = 6'($urandom); temp_second = 6'($urandom);
      month = 4'($urandom); day = 5'($urandom); week = 3'($urandom);
      year = YW'($urandom_range(0, 16383));
      wait_tick();
      grab_frame();
      for (int d = 0; d < 8; d++) begin
        checks++;
        if (got_num[d] !== 4'(model_digit(d))) begin
          errors++;
          $display("FAIL rand%0d_digit%0d: mode %0d year %0d got %0d required %0d", it, d, mode, year, got_num[d], model_digit(d));
        end
      end
    end
  endtask

  task automatic test_year();
    int yrs[6] = '{2024, 1900, 10000, 1911, 9999, 0};
    int exp_2024[8] = '{2, 0, 2, 4, 0, 1, 1, 3};
    int old0;
    mode = 3'd3;
    for (int k = 0; k < 6; k++) begin
      year = YW'(yrs[k]);
      wait_tick();
      grab_frame();
      for (int d = 0; d < 8; d++) begin
        checks++;
        if (got_num[d] !== 4'(model_digit(d))) begin
          errors++;
          $display("FAIL year%0d_digit%0d: got %0d required %0d", yrs[k], d, got_num[d], model_digit(d));
        end
      end
    end
    year = YW'(2024);
    wait_tick();
    grab_frame();
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (got_num[d] !== 4'(exp_2024[d])) begin errors++; $display("FAIL year2024_const%0d: got %0d required %0d", d, got_num[d], exp_2024[d]); end
    end
    old0 = model_digit(0);
    year = YW'(1900);
    grab_frame();
    checks++;
    if (got_num[0] !== 4'(old0)) begin errors++; $display("FAIL year_digit0_prev: got %0d required %0d", got_num[0], old0); end
    for (int d = 1; d < 8; d++) begin
      checks++;
      if (got_num[d] !== 4'(model_digit(d))) begin errors++; $display("FAIL year_new_digit%0d: got %0d required %0d", d, got_num[d], model_digit(d)); end
    end
  endtask

  task automatic test_snapshot();
    mode = 3'd1; hour = 6'd23; minute = 6'd59; second = 6'd7;
    wait_tick();
    wait_tick();
    repeat (3 * SD + 8) @(negedge clk);
    minute = 6'd0;
    repeat (8) @(negedge clk);
    checks++;
    if (num !== 4'd5) begin errors++; $display("FAIL snap_digit3: got %0d required 5", num); end
    repeat (SD) @(negedge clk);
    checks++;
    if (num !== 4'd9) begin errors++; $display("FAIL snap_digit4: got %0d required 9", num); end
    grab_frame();
    for (int d = 0; d < 8; d++) begin
      checks++;
      if (got_num[d] !== 4'(model_digit(d))) begin errors++; $display("FAIL snap_next%0d: got %0d required %0d", d, got_num[d], model_digit(d)); end
    end
  endtask

  task automatic test_blink();
    int ph, cnt, ef, e;
    mode = 3'd1; hour = 6'd12; minute = 6'd34; second = 6'd56;
    wait_tick();
    edit_field = 2'd2;
    ph = 1; cnt = 0; ef = 2;
    for (int k = 1; k <= 6; k++) begin
      grab_frame();
      if (cnt == BD - 1) begin cnt = 0; ph = 1 - ph; end
      else cnt++;
      for (int d = 0; d < 8; d++) begin
        e = (ph == 0 && pair_of(d, ef)) ? 15 : model_digit(d);
        checks++;
        if (got_num[d] !== 4'(e)) begin errors++; $display("FAIL blink_f%0d_digit%0d: got %0d required %0d", k, d, got_num[d], e); end
      end
      if (k == 2) begin
        edit_field = 2'd3;
        ef = 3; ph = 1; cnt = 0;
      end
    end
    edit_field = 2'd0;
    wait_tick();
  endtask

  task automatic test_reset_midconv();
    mode = 3'd3; year = YW'(2024);
    wait_tick();
    grab_frame();
    wait_tick();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 8; d++) begin
      repeat ((d == 0) ? 16 : SD) @(negedge clk);
      checks++;
      if (num !== 4'd0 || light !== 3'(d)) begin
        errors++;
        $display("FAIL midconv_digit%0d: got num %0d light %0d required num 0 light %0d", d, num, light, d);
      end
    end
    wait_tick();
    repeat (2) @(negedge clk);
    checks++;
    if (num !== 4'd0) begin errors++; $display("FAIL midconv_early: got %0d required 0", num); end
    repeat (2 * YW + 1) @(negedge clk);
    checks++;
    if (num !== 4'd2) begin errors++; $display("FAIL midconv_load: got %0d required 2", num); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_time();
    test_random();
    test_year();
    test_snapshot();
    test_blink();
    test_reset_midconv();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
